// File: rtl/gcn_multiclass.sv
// One-layer GCN engine: loads class weights, transforms each node row (X*W), aggregates over a
// COO edge list with saturating adds, then emits a per-node argmax class index.
module gcn_multiclass #(
    parameter int unsigned FEATURE_COLS      = 96,
    parameter int unsigned FEATURE_ROWS      = 6,
    parameter int unsigned WEIGHT_COLS       = 3,
    parameter int unsigned FEATURE_WIDTH     = 5,
    parameter int unsigned WEIGHT_WIDTH      = 5,
    parameter int unsigned DOT_PROD_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH     = 13,
    parameter int unsigned FEATURE_BASE      = 512,
    parameter int unsigned MAX_EDGES         = 16,
    parameter int unsigned COO_BW            = $clog2(MAX_EDGES),
    parameter int unsigned NODE_BW           = $clog2(FEATURE_ROWS),
    parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [COO_BW:0]                           num_edges,
    input  logic                                      self_loop,
    input  logic [FEATURE_COLS*WEIGHT_WIDTH-1:0]      data_in,
    input  logic [2*NODE_BW-1:0]                      coo_in,
    output logic [COO_BW-1:0]                         coo_address,
    output logic [ADDRESS_WIDTH-1:0]                  read_address,
    output logic                                      enable_read,
    output logic                                      done,
    output logic                                      edge_error,
    output logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] max_addi_answer
);

    localparam int unsigned DW      = DOT_PROD_WIDTH;
    localparam int unsigned PW      = FEATURE_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned DATA_W  = FEATURE_COLS * WEIGHT_WIDTH;
    localparam int unsigned MAW     = MAX_ADDRESS_WIDTH;
    localparam int unsigned EW      = COO_BW + 1;
    localparam int unsigned CNT_MAX = (WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [WEIGHT_COLS-1:0][DW-1:0] row_t;

    typedef enum logic [2:0] {
        StIdle, StLoadW, StXform, StAggInit, StAgg, StArgmax, StDone
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q;
    logic [EW-1:0]                   edge_q;
    logic [EW-1:0]                   ne_q;
    logic                            sl_q;
    logic [DATA_W-1:0]               w_q [WEIGHT_COLS];
    row_t                            t_q [FEATURE_ROWS];
    row_t                            a_q [FEATURE_ROWS];
    logic [FEATURE_ROWS-1:0][MAW-1:0] ans_q;

    logic [EW-1:0]      ne_clamped;
    logic [NODE_BW-1:0] src, dst;
    logic               edge_ok;
    logic               last_edge;
    row_t               xform_row, t_src, t_dst;

    function automatic logic [DW-1:0] dot(input logic [DATA_W-1:0] f, input logic [DATA_W-1:0] w);
        logic [DW-1:0] acc;
        logic [PW-1:0] p;
        acc = '0;
        for (int i = 0; i < FEATURE_COLS; i++) begin
            p   = PW'(f[i*WEIGHT_WIDTH +: FEATURE_WIDTH]) * PW'(w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            acc = acc + DW'(p);
        end
        return acc;
    endfunction

    function automatic row_t add_row(input row_t a, input row_t b);
        row_t         r;
        logic [DW:0]  s;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            s    = {1'b0, a[c]} + {1'b0, b[c]};
            r[c] = s[DW] ? {DW{1'b1}} : s[DW-1:0];
        end
        return r;
    endfunction

    // Strict '>' keeps the lowest index on ties.
    function automatic logic [MAW-1:0] argmax(input row_t r);
        logic [MAW-1:0] best;
        logic [DW-1:0]  bv;
        best = '0;
        bv   = r[0];
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (r[c] > bv) begin
                bv   = r[c];
                best = MAW'(c);
            end
        end
        return best;
    endfunction

    assign ne_clamped      = (num_edges > EW'(MAX_EDGES)) ? EW'(MAX_EDGES) : num_edges;
    assign src             = coo_in[2*NODE_BW-1 -: NODE_BW];
    assign dst             = coo_in[NODE_BW-1:0];
    assign edge_ok         = (32'(src) < FEATURE_ROWS) && (32'(dst) < FEATURE_ROWS);
    assign last_edge       = (edge_q + EW'(1)) == ne_q;
    assign coo_address     = edge_q[COO_BW-1:0];
    assign max_addi_answer = ans_q;

    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            xform_row[c] = dot(data_in, w_q[c]);
        end
    end

    always_comb begin
        t_src = '0;
        t_dst = '0;
        for (int n = 0; n < FEATURE_ROWS; n++) begin
            if (src == NODE_BW'(n)) t_src = t_q[n];
            if (dst == NODE_BW'(n)) t_dst = t_q[n];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StLoadW;
            StLoadW:   if (cnt_q == CNT_W'(WEIGHT_COLS)) state_d = StXform;
            StXform:   if (cnt_q == CNT_W'(FEATURE_ROWS)) state_d = StAggInit;
            StAggInit: state_d = (ne_q == '0) ? StArgmax : StAgg;
            StAgg:     if (last_edge) state_d = StArgmax;
            StArgmax:  if (cnt_q == CNT_W'(FEATURE_ROWS - 1)) state_d = StDone;
            StDone:    if (!start) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Read-port outputs
    always_comb begin
        enable_read  = 1'b0;
        read_address = '0;
        unique case (state_q)
            StLoadW: begin
                if (cnt_q < CNT_W'(WEIGHT_COLS)) begin
                    enable_read  = 1'b1;
                    read_address = ADDRESS_WIDTH'(cnt_q);
                end
            end
            StXform: begin
                if (cnt_q < CNT_W'(FEATURE_ROWS)) begin
                    enable_read  = 1'b1;
                    read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(cnt_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath; read data lags the address by one cycle, hence the cnt-1 capture slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            edge_q     <= '0;
            ne_q       <= '0;
            sl_q       <= 1'b0;
            done       <= 1'b0;
            edge_error <= 1'b0;
            ans_q      <= '0;
            for (int c = 0; c < WEIGHT_COLS; c++) w_q[c] <= '0;
            for (int n = 0; n < FEATURE_ROWS; n++) begin
                t_q[n] <= '0;
                a_q[n] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ne_q       <= ne_clamped;
                        sl_q       <= self_loop;
                        edge_error <= 1'b0;
                        done       <= 1'b0;
                        cnt_q      <= '0;
                        edge_q     <= '0;
                    end
                end
                StLoadW: begin
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        if (cnt_q == CNT_W'(c + 1)) w_q[c] <= data_in;
                    end
                    cnt_q <= (cnt_q == CNT_W'(WEIGHT_COLS)) ? '0 : cnt_q + CNT_W'(1);
                end
                StXform: begin
                    for (int n = 0; n < FEATURE_ROWS; n++) begin
                        if (cnt_q == CNT_W'(n + 1)) t_q[n] <= xform_row;
                    end
                    cnt_q <= (cnt_q == CNT_W'(FEATURE_ROWS)) ? '0 : cnt_q + CNT_W'(1);
                end
                StAggInit: begin
                    for (int n = 0; n < FEATURE_ROWS; n++) a_q[n] <= sl_q ? t_q[n] : '0;
                    cnt_q <= '0;
                end
                StAgg: begin
                    if (edge_ok) begin
                        // A self-edge matches only the src branch, so it is added once.
                        for (int n = 0; n < FEATURE_ROWS; n++) begin
                            if (src == NODE_BW'(n))      a_q[n] <= add_row(a_q[n], t_dst);
                            else if (dst == NODE_BW'(n)) a_q[n] <= add_row(a_q[n], t_src);
                        end
                    end else begin
                        edge_error <= 1'b1;
                    end
                    if (!last_edge) edge_q <= edge_q + EW'(1);
                end
                StArgmax: begin
                    for (int n = 0; n < FEATURE_ROWS; n++) begin
                        if (cnt_q == CNT_W'(n)) ans_q[n] <= argmax(a_q[n]);
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StDone: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_multiclass.sv
// Self-checking bench for gcn_multiclass: randomized and directed graphs compared against an
// integer reference model of the transform/aggregate/argmax rules.
module tb_gcn_multiclass;

    localparam int FC = 96;
    localparam int FR = 6;
    localparam int WC = 3;
    localparam int ME = 16;
    localparam int MAXV = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_edges;
    logic        self_loop;
    logic [479:0] data_in;
    logic [5:0]  coo_in;
    logic [3:0]  coo_address;
    logic [12:0] read_address;
    logic        enable_read;
    logic        done;
    logic        edge_error;
    logic [11:0] max_addi_answer;

    int feat [FR][FC];
    int wt   [WC][FC];
    int esrc [ME];
    int edst [ME];
    int exp_ans [FR];
    bit exp_err;
    int checks = 0;
    int errors = 0;

    gcn_multiclass dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_edges       (num_edges),
        .self_loop       (self_loop),
        .data_in         (data_in),
        .coo_in          (coo_in),
        .coo_address     (coo_address),
        .read_address    (read_address),
        .enable_read     (enable_read),
        .done            (done),
        .edge_error      (edge_error),
        .max_addi_answer (max_addi_answer)
    );

    always #5 clk = ~clk;

    // Memory: weights at 0..WC-1, features from 512; one-cycle read latency.
    function automatic logic [479:0] mem_row(input logic [12:0] a);
        logic [479:0] v;
        int idx;
        v   = '0;
        idx = int'(a);
        for (int i = 0; i < FC; i++) begin
            if (idx < WC) v[i*5 +: 5] = 5'(wt[idx][i]);
            else if (idx >= 512 && idx < 512 + FR) v[i*5 +: 5] = 5'(feat[idx-512][i]);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (enable_read) data_in <= mem_row(read_address);
    end

    assign coo_in = {3'(esrc[coo_address]), 3'(edst[coo_address])};

    // Reference: T wraps mod 2^16; saturation of non-negative sums equals clamping the total.
    task automatic model(input int ne_req, input bit sl);
        longint t [FR][WC];
        longint acc [FR][WC];
        int ne;
        int best;
        ne = (ne_req > ME) ? ME : ne_req;
        exp_err = 1'b0;
        for (int n = 0; n < FR; n++) begin
            for (int c = 0; c < WC; c++) begin
                t[n][c] = 0;
                for (int i = 0; i < FC; i++) t[n][c] += longint'(feat[n][i] * wt[c][i]);
                t[n][c] = t[n][c] % 65536;
                acc[n][c] = sl ? t[n][c] : 0;
            end
        end
        for (int e = 0; e < ne; e++) begin
            if (esrc[e] < FR && edst[e] < FR) begin
                for (int c = 0; c < WC; c++) begin
                    if (esrc[e] == edst[e]) acc[esrc[e]][c] += t[esrc[e]][c];
                    else begin
                        acc[esrc[e]][c] += t[edst[e]][c];
                        acc[edst[e]][c] += t[esrc[e]][c];
                    end
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        for (int n = 0; n < FR; n++) begin
            for (int c = 0; c < WC; c++) if (acc[n][c] > MAXV) acc[n][c] = MAXV;
            best = 0;
            for (int c = 1; c < WC; c++) if (acc[n][c] > acc[n][best]) best = c;
            exp_ans[n] = best;
        end
    endtask

    task automatic run_job(input int ne, input bit sl, output int lat);
        @(negedge clk);
        num_edges = 5'(ne);
        self_loop = sl;
        start     = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!done && lat < 300);
    endtask

    task automatic end_job();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ring();
        for (int e = 0; e < ME; e++) begin
            esrc[e] = (e < FR) ? e : 0;
            edst[e] = (e < FR) ? (e + 1) % FR : 0;
        end
    endtask

    task automatic set_data(input int fval, input int w0, input int w1, input int w2);
        for (int n = 0; n < FR; n++) for (int i = 0; i < FC; i++) feat[n][i] = fval;
        for (int i = 0; i < FC; i++) begin
            wt[0][i] = w0;
            wt[1][i] = w1;
            wt[2][i] = w2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        num_edges = '0;
        self_loop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (edge_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", edge_error); end
        checks++;
        if (enable_read !== 1'b0 || read_address !== 13'd0) begin
            errors++; $display("FAIL reset_read got en=%b addr=%0d want 0/0", enable_read, read_address);
        end
        checks++;
        if (coo_address !== 4'd0 || max_addi_answer !== 12'd0) begin
            errors++; $display("FAIL reset_out got coo=%0d ans=%h want 0/0", coo_address, max_addi_answer);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ring_self_loop();
        int lat;
        set_data(1, 1, 2, 3);
        set_ring();
        model(6, 1'b1);
        run_job(6, 1'b1, lat);
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL ring_latency got %0d want 25", lat); end
        for (int n = 0; n < FR; n++) begin
            checks++;
            if (int'(max_addi_answer[n*2 +: 2]) !== 2 || exp_ans[n] !== 2) begin
                errors++; $display("FAIL ring_ans node %0d got %0d want 2", n, max_addi_answer[n*2 +: 2]);
            end
        end
        end_job();
    endtask

    task automatic test_tie();
        int lat;
        set_data(1, 7, 7, 7);
        set_ring();
        model(6, 1'b0);
        run_job(6, 1'b0, lat);
        for (int n = 0; n < FR; n++) begin
            checks++;
            if (int'(max_addi_answer[n*2 +: 2]) !== 0) begin
                errors++; $display("FAIL tie_ans node %0d got %0d want 0", n, max_addi_answer[n*2 +: 2]);
            end
        end
        end_job();
    endtask

    task automatic test_saturate();
        int lat;
        for (int e = 0; e < ME; e++) begin
            esrc[e] = 0;
            edst[e] = 1 + e % 5;
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_data(31, 31, 31, 31);
            else        set_data(31, 31, 30, 29);
            model(16, 1'b1);
            run_job(16, 1'b1, lat);
            checks++;
            if (lat !== 3 + 12 + 16 + 4) begin
                errors++; $display("FAIL sat_latency run %0d got %0d want %0d", k, lat, 35);
            end
            checks++;
            if (edge_error !== 1'b0) begin errors++; $display("FAIL sat_err got %b want 0", edge_error); end
            for (int n = 0; n < FR; n++) begin
                checks++;
                if (int'(max_addi_answer[n*2 +: 2]) !== exp_ans[n]) begin
                    errors++;
                    $display("FAIL sat_ans run %0d node %0d got %0d want %0d", k, n,
                             max_addi_answer[n*2 +: 2], exp_ans[n]);
                end
            end
            end_job();
        end
    endtask

    task automatic test_bad_edge();
        int lat;
        for (int n = 0; n < FR; n++) for (int i = 0; i < FC; i++) feat[n][i] = int'($urandom_range(0, 31));
        for (int c = 0; c < WC; c++) for (int i = 0; i < FC; i++) wt[c][i] = int'($urandom_range(0, 31));
        set_ring();
        esrc[2] = 7;
        edst[2] = 2;
        model(6, 1'b1);
        run_job(6, 1'b1, lat);
        checks++;
        if (edge_error !== 1'b1 || exp_err !== 1'b1) begin
            errors++; $display("FAIL bad_edge_err got %b want 1", edge_error);
        end
        for (int n = 0; n < FR; n++) begin
            checks++;
            if (int'(max_addi_answer[n*2 +: 2]) !== exp_ans[n]) begin
                errors++; $display("FAIL bad_edge_ans node %0d got %0d want %0d", n,
                                   max_addi_answer[n*2 +: 2], exp_ans[n]);
            end
        end
        end_job();
        checks++;
        if (edge_error !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL bad_edge_idle got err=%b done=%b want 1/1", edge_error, done);
        end
    endtask

    task automatic test_no_edges();
        int lat;
        for (int n = 0; n < FR; n++) for (int i = 0; i < FC; i++) feat[n][i] = int'($urandom_range(0, 31));
        for (int c = 0; c < WC; c++) for (int i = 0; i < FC; i++) wt[c][i] = int'($urandom_range(0, 31));
        model(0, 1'b1);
        run_job(0, 1'b1, lat);
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL no_edges_latency got %0d want 19", lat); end
        for (int n = 0; n < FR; n++) begin
            checks++;
            if (int'(max_addi_answer[n*2 +: 2]) !== exp_ans[n]) begin
                errors++; $display("FAIL no_edges_ans node %0d got %0d want %0d", n,
                                   max_addi_answer[n*2 +: 2], exp_ans[n]);
            end
        end
        end_job();
    endtask

    task automatic test_random();
        int lat, ne, ne_eff;
        bit sl;
        for (int it = 0; it < 8; it++) begin
            for (int n = 0; n < FR; n++) for (int i = 0; i < FC; i++) feat[n][i] = int'($urandom_range(0, 31));
            for (int c = 0; c < WC; c++) for (int i = 0; i < FC; i++) wt[c][i] = int'($urandom_range(0, 31));
            for (int e = 0; e < ME; e++) begin
                esrc[e] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
                edst[e] = int'($urandom_range(0, 5));
            end
            ne     = int'($urandom_range(0, 20));
            sl     = 1'($urandom_range(0, 1));
            ne_eff = (ne > ME) ? ME : ne;
            model(ne, sl);
            run_job(ne, sl, lat);
            checks++;
            if (lat !== WC + 2 * FR + ne_eff + 4) begin
                errors++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, WC + 2*FR + ne_eff + 4);
            end
            checks++;
            if (edge_error !== exp_err) begin
                errors++; $display("FAIL rand_err it %0d got %b want %b", it, edge_error, exp_err);
            end
            for (int n = 0; n < FR; n++) begin
                checks++;
                if (int'(max_addi_answer[n*2 +: 2]) !== exp_ans[n]) begin
                    errors++; $display("FAIL rand_ans it %0d node %0d got %0d want %0d", it, n,
                                       max_addi_answer[n*2 +: 2], exp_ans[n]);
                end
            end
            end_job();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_data(1, 1, 2, 3);
        set_ring();
        model(6, 1'b1);
        run_job(6, 1'b1, lat);
        // start stays high: must not retrigger
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || enable_read !== 1'b0) begin
                errors++; $display("FAIL hold_start cycle %0d got done=%b en=%b want 1/0", i, done, enable_read);
            end
        end
        end_job();
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL idle_done got %b want 1", done); end
        run_job(6, 1'b1, lat);
        checks++;
        if (lat !== 25) begin errors++; $display("FAIL b2b_latency got %0d want 25", lat); end
        checks++;
        if (int'(max_addi_answer[0 +: 2]) !== exp_ans[0]) begin
            errors++; $display("FAIL b2b_ans got %0d want %0d", max_addi_answer[0 +: 2], exp_ans[0]);
        end
        end_job();
    endtask

    task automatic test_reset_mid_agg();
        int lat;
        set_data(1, 1, 2, 3);
        set_ring();
        esrc[0] = 7;
        @(negedge clk);
        num_edges = 5'd16;
        self_loop = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (edge_error !== 1'b1) begin errors++; $display("FAIL mid_agg_err got %b want 1", edge_error); end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || edge_error !== 1'b0 || enable_read !== 1'b0) begin
            errors++; $display("FAIL mid_reset got done=%b err=%b en=%b want 0/0/0", done, edge_error, enable_read);
        end
        checks++;
        if (max_addi_answer !== 12'd0) begin
            errors++; $display("FAIL mid_reset_ans got %h want 0", max_addi_answer);
        end
        @(negedge clk);
        reset = 1'b0;
        set_ring();
        model(6, 1'b1);
        run_job(6, 1'b1, lat);
        checks++;
        if (lat !== 25 || edge_error !== 1'b0) begin
            errors++; $display("FAIL post_reset got lat=%0d err=%b want 25/0", lat, edge_error);
        end
        for (int n = 0; n < FR; n++) begin
            checks++;
            if (int'(max_addi_answer[n*2 +: 2]) !== exp_ans[n]) begin
                errors++; $display("FAIL post_reset_ans node %0d got %0d want %0d", n,
                                   max_addi_answer[n*2 +: 2], exp_ans[n]);
            end
        end
        end_job();
    endtask

    initial begin
        data_in = '0;
        set_data(0, 0, 0, 0);
        set_ring();
        test_reset();
        test_ring_self_loop();
        test_tie();
        test_saturate();
        test_bad_edge();
        test_no_edges();
        test_random();
        test_back_to_back();
        test_reset_mid_agg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcn_multiclass.md
Name: gcn_multiclass

Overview:
- Parametrised successor to the current fixed 6-node/3-class GCN engine; one layer of graph convolution followed by per-node classification.
- Computes `X·W` (node features × class weights) and aggregates over an undirected COO edge list, with an optional self-loop term.
- Emits a per-node argmax class index.
- Generalised in node count, class count, feature length and edge capacity; adds a runtime edge count, a self-loop mode, saturating aggregation and a malformed-edge error flag.
- Sits between the shared feature/weight memory port and the COO edge store.

Parameters:
- FEATURE_COLS, 96, feature vector length (= weight row length)
- FEATURE_ROWS, 6, number of graph nodes
- WEIGHT_COLS, 3, number of classes (weight vectors)
- FEATURE_WIDTH, 5, unsigned feature element width
- WEIGHT_WIDTH, 5, unsigned weight element width
- DOT_PROD_WIDTH, 16, width of transformed and aggregated values
- ADDRESS_WIDTH, 13, memory read address width
- FEATURE_BASE, 512, address of feature row 0; weight vector c is at address c
- MAX_EDGES, 16, COO edge capacity
- COO_BW, $clog2(MAX_EDGES), edge index width
- NODE_BW, $clog2(FEATURE_ROWS), node index width in COO entries
- MAX_ADDRESS_WIDTH, $clog2(WEIGHT_COLS), class index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  level; sampled only in IDLE
- num_edges  in  COO_BW+1  edges to process (0..MAX_EDGES), latched at start
- self_loop  in  1  add node's own transformed row during aggregation, latched at start
- data_in  in  FEATURE_COLS x WEIGHT_WIDTH  read data, valid one cycle after enable_read
- coo_in  in  2*NODE_BW  {src, dst} for coo_address, combinational
- coo_address  out  COO_BW  edge index
- read_address  out  ADDRESS_WIDTH  memory read address
- enable_read  out  1  read strobe
- done  out  1  results valid
- edge_error  out  1  sticky: a skipped edge had an out-of-range node index
- max_addi_answer  out  FEATURE_ROWS x MAX_ADDRESS_WIDTH  per-node class index

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, internal arrays cleared. Reset asserted mid-run aborts within the same edge; no partial done.
- IDLE:
  - On start=1, latch num_edges (clamped to MAX_EDGES) and self_loop, clear edge_error and done, go to LOAD_W.
  - max_addi_answer retains its previous value until overwritten in ARGMAX.
- LOAD_W:
  - Issue enable_read=1 with read_address=c for c=0..WEIGHT_COLS-1 on consecutive cycles.
  - Capture data_in one cycle later into weight register c.
  - Takes WEIGHT_COLS+1 cycles.
- XFORM:
  - Issue reads at FEATURE_BASE+n for n=0..FEATURE_ROWS-1.
  - On each captured row, compute all WEIGHT_COLS dot products in parallel and store T[n][c].
  - Products are unsigned FEATURE_WIDTH+WEIGHT_WIDTH bits; the sum wraps modulo 2^DOT_PROD_WIDTH.
  - Takes FEATURE_ROWS+1 cycles.
  - enable_read is 0 in all other states.
- AGG_INIT (1 cycle): A[n][c] = self_loop ? T[n][c] : 0.
- AGG:
  - For e=0..num_edges-1, one edge per cycle: drive coo_address=e and read coo_in.
  - If src<FEATURE_ROWS and dst<FEATURE_ROWS: A[src] += T[dst], and A[dst] += T[src].
  - A self-edge (src==dst) adds T[src] once, not twice.
  - Otherwise skip the edge and set edge_error.
  - Additions saturate at 2^DOT_PROD_WIDTH-1.
  - num_edges=0 skips straight to ARGMAX.
  - coo_address holds its last value outside AGG.
- ARGMAX:
  - One node per cycle; max_addi_answer[n] = the index of the largest A[n][c].
  - Ties resolve to the lowest index; all-zero yields 0.
  - Takes FEATURE_ROWS cycles.
- DONE:
  - done=1 and outputs stable while start=1.
  - Return to IDLE when start=0, with done held until the next start is accepted.
  - start high continuously does not retrigger; it must drop first.
- Latency: from the start-sampling edge to done=1 is exactly WEIGHT_COLS + 2*FEATURE_ROWS + num_edges + 4 cycles.

Test Plan:
- Default params, all features=1, W row0=1, row1=2, row2=3, edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0), self_loop=1 -> T[n]={96,192,288}, every answer=2, done at cycle 3+12+6+4=25.
- Same data, W all 7, self_loop=0 -> all classes tie, every answer=0.
- Feature rows and weights set to 31 with num_edges=16 in a star on node 0 -> A[0] saturates at 65535 without wrap, answer[0]=0 (tie), edge_error=0.
- Edge list containing (7,2) with NODE_BW=3 -> edge skipped, edge_error=1 held through done; other answers match the model.
- num_edges=0, self_loop=1 -> answers equal per-node argmax of T; done at cycle 3+12+0+4=19.
- Reset pulsed during AGG, then a fresh start -> done=0 on the next cycle and edge_error cleared; second run produces the gold answers.
